// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory
// and loads the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        im_rd_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [29:0] LIMIT = 30'(IMEM_WORDS);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] instr_nxt;
  logic [31:0] pc4_nxt;
  logic        valid_nxt;
  logic        fault_nxt;
  logic [31:0] fault_pc_nxt;
  logic [31:0] count_nxt;
  logic        illegal;
  logic        redirect;
  logic [31:0] redirect_pc;

  assign pc_plus4    = pc + 32'd4;
  assign illegal     = (pc[1:0] != 2'b00) || (pc[31:2] >= LIMIT);
  assign redirect    = jump || branch_taken;
  assign redirect_pc = jump ? jump_target : branch_target;

  assign im_addr  = pc;
  assign im_rd_en = (state == FETCH) && !stall;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = ifid_instr;
    pc4_nxt      = ifid_pc4;
    valid_nxt    = ifid_valid;
    fault_nxt    = fetch_fault;
    fault_pc_nxt = fault_pc;
    count_nxt    = fetch_count;
    if (stall) begin
      // ID re-presents any redirect once the stall clears
      state_nxt = state;
    end else if (redirect) begin
      pc_nxt    = redirect_pc;
      instr_nxt = NOP_INSTR;
      pc4_nxt   = 32'd0;
      valid_nxt = 1'b0;
      state_nxt = FETCH;
    end else if (state == FETCH && illegal) begin
      instr_nxt = NOP_INSTR;
      pc4_nxt   = 32'd0;
      valid_nxt = 1'b0;
      state_nxt = HALT;
      if (!fetch_fault) begin
        fault_nxt    = 1'b1;
        fault_pc_nxt = pc;
      end
    end else if (state == FETCH) begin
      instr_nxt = im_instr;
      pc4_nxt   = pc_plus4;
      valid_nxt = 1'b1;
      pc_nxt    = pc_plus4;
      count_nxt = fetch_count + 32'd1;
    end else begin
      instr_nxt = NOP_INSTR;
      pc4_nxt   = 32'd0;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ifid_instr  <= NOP_INSTR;
      ifid_pc4    <= 32'd0;
      ifid_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ifid_instr  <= instr_nxt;
      ifid_pc4    <= pc4_nxt;
      ifid_valid  <= valid_nxt;
      fetch_fault <= fault_nxt;
      fault_pc    <= fault_pc_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, fault/reset sequences
// and randomized traffic against a behavioural fetch model.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        im_rd_en;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .im_rd_en(im_rd_en), .im_addr(im_addr), .im_instr(im_instr),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .fetch_fault(fetch_fault),
    .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  assign im_instr = mem[im_addr[8:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_fpc;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_halt = 0; m_instr = 0; m_pc4 = 0;
    m_valid = 0; m_fault = 0; m_fpc = 0; m_cnt = 0;
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 128);
  endfunction

  task automatic bubble();
    m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic s, input logic b,
                            input logic [31:0] bt, input logic j,
                            input logic [31:0] jt);
    if (s) begin
    end else if (j || b) begin
      m_pc = j ? jt : bt;
      bubble();
      m_halt = 0;
    end else if (m_halt) begin
      bubble();
    end else if (bad_addr(m_pc)) begin
      bubble();
      m_halt = 1;
      if (!m_fault) begin
        m_fault = 1;
        m_fpc = m_pc;
      end
    end else begin
      m_instr = mem[(m_pc / 4) % 128];
      m_pc4 = m_pc + 4;
      m_valid = 1;
      m_pc = m_pc + 4;
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_model();
    chk("im_addr", im_addr, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("fault_pc", fault_pc, m_fpc);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic cycle(input logic s, input logic b,
                       input logic [31:0] bt, input logic j,
                       input logic [31:0] jt);
    stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    #1;
    chk("im_rd_en", {31'd0, im_rd_en}, {31'd0, !m_halt && !s});
    model_step(s, b, bt, j, jt);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        rd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, 127) * 4);
    if (r < 9) return 32'($urandom_range(120, 200) * 4);
    return 32'($urandom_range(0, 511) * 4 + 2);
  endfunction

  initial begin
    mem[0] = 32'h00222820;
    mem[1] = 32'h20610006;
    mem[2] = 32'h00823022;
    mem[3] = 32'hAC640004;
    for (int i = 4; i < 128; i++) mem[i] = 32'hA500_0000 | 32'(i);

    vecs[0]  = '{0, 0, 0, 0, 0, 1, 32'h04, 32'h00222820, 32'h04, 1, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 32'h08, 32'h20610006, 32'h08, 1, 2};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 32'h08, 32'h20610006, 32'h08, 1, 2};
    vecs[3]  = '{1, 1, 32'h40, 0, 0, 0, 32'h08, 32'h20610006, 32'h08, 1, 2};
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 32'h0C, 32'h00823022, 32'h0C, 1, 3};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 32'h10, 32'hAC640004, 32'h10, 1, 4};
    vecs[6]  = '{0, 1, 32'h40, 0, 0, 1, 32'h40, 32'h0, 32'h0, 0, 4};
    vecs[7]  = '{0, 0, 0, 0, 0, 1, 32'h44, 32'hA500_0010, 32'h44, 1, 5};
    vecs[8]  = '{0, 1, 32'h40, 1, 32'h20, 1, 32'h20, 32'h0, 32'h0, 0, 5};
    vecs[9]  = '{1, 0, 0, 1, 32'h80, 0, 32'h20, 32'h0, 32'h0, 0, 5};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 32'h24, 32'hA500_0008, 32'h24, 1, 6};

    reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
    jump = 0; jump_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("reset_rd_en", {31'd0, im_rd_en}, 32'd1);
    reset = 0;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br;
      branch_target = vecs[i].bt; jump = vecs[i].jmp;
      jump_target = vecs[i].jt;
      #1;
      chk("vec_rd_en", {31'd0, im_rd_en}, {31'd0, vecs[i].rd});
      model_step(vecs[i].stall, vecs[i].br, vecs[i].bt,
                 vecs[i].jmp, vecs[i].jt);
      @(posedge clk);
      #1;
      chk("vec_pc", im_addr, vecs[i].pc);
      chk("vec_instr", ifid_instr, vecs[i].instr);
      chk("vec_pc4", ifid_pc4, vecs[i].pc4);
      chk("vec_valid", {31'd0, ifid_valid}, {31'd0, vecs[i].valid});
      chk("vec_count", fetch_count, vecs[i].cnt);
      check_model();
    end

    // Run off the end of memory, halt, then recover via jumps
    cycle(0, 0, 0, 1, 32'h1F8);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("end_pc", im_addr, 32'h200);
    cycle(0, 0, 0, 0, 0);
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("fault_pc_first", fault_pc, 32'h200);
    cycle(0, 0, 0, 0, 0);
    chk("halt_rd_en", {31'd0, im_rd_en}, 32'd0);
    chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
    cycle(0, 0, 0, 1, 32'h4);
    cycle(0, 0, 0, 0, 0);
    chk("resume_instr", ifid_instr, 32'h20610006);
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    cycle(0, 0, 0, 1, 32'h6);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("fault_pc_kept", fault_pc, 32'h200);
    chk("refault_pc", im_addr, 32'h6);

    // Asynchronous reset mid-stall while halted
    stall = 1;
    #2;
    reset = 1;
    #1;
    model_reset();
    check_model();
    chk("async_rd_en", {31'd0, im_rd_en}, 32'd0);
    @(posedge clk);
    #1;
    stall = 0;
    chk("reset_hold_pc", im_addr, 32'h0);
    reset = 0;

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), rand_target(),
            ($urandom_range(0, 9) == 0), rand_target());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
